// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master round-robin arbiter driving a single-outstanding bus with wait-state timeout
module bus_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic        m1_req,
    input  logic        m0_wen,
    input  logic        m1_wen,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m0_wdata,
    input  logic [31:0] m1_wdata,
    output logic        m0_gnt,
    output logic        m1_gnt,
    output logic        m0_done,
    output logic        m1_done,
    output logic [31:0] m_rdata,
    output logic        m_err,
    output logic [31:0] Bus_addr,
    output logic        Bus_wen,
    output logic [31:0] Bus_wdata,
    output logic        bus_valid,
    input  logic [31:0] Bus_rdata,
    input  logic        bus_ready
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);
    state_t      state_q, state_d;
    logic        owner_q, owner_d, ptr_q, ptr_d, wen_q, wen_d, err_q, err_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic        busy;
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        wen_d   = wen_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        m0_gnt  = 1'b0;
        m1_gnt  = 1'b0;
        m0_done = 1'b0;
        m1_done = 1'b0;
        case (state_q)
            IDLE: begin
                // a grant on a reset edge is never accepted, so it is not shown
                m0_gnt = rst_n && m0_req && (!m1_req || !ptr_q);
                m1_gnt = rst_n && m1_req && (!m0_req || ptr_q);
                if (m0_gnt || m1_gnt) begin
                    state_d = BUSY;
                    owner_d = m1_gnt;
                    cnt_d   = 8'd0;
                    wen_d   = m1_gnt ? m1_wen : m0_wen;
                    addr_d  = m1_gnt ? m1_addr : m0_addr;
                    wdata_d = m1_gnt ? m1_wdata : m0_wdata;
                end
            end
            BUSY: begin
                if (bus_ready) begin
                    state_d = RESP;
                    rdata_d = wen_q ? 32'd0 : Bus_rdata;
                    err_d   = 1'b0;
                end else if (cnt_q == LAST) begin
                    state_d = RESP;
                    rdata_d = 32'd0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                m0_done = !owner_q;
                m1_done = owner_q;
                ptr_d   = !owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            ptr_q   <= 1'b0;
            wen_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= 8'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            wen_q   <= wen_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end
    assign busy      = (state_q == BUSY);
    assign bus_valid = busy;
    assign Bus_wen   = busy && wen_q;
    assign Bus_addr  = busy ? addr_q : 32'd0;
    assign Bus_wdata = busy ? wdata_q : 32'd0;
    assign m_rdata   = rdata_q;
    assign m_err     = err_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed cycle-by-cycle checks of grant order, bus timing, timeout and reset abort
module tb_bus_arbiter;
    logic        clk = 1'b0;
    logic        rst_n, m0_req, m1_req, m0_wen, m1_wen;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic        m0_gnt, m1_gnt, m0_done, m1_done, m_err;
    logic [31:0] m_rdata, Bus_addr, Bus_wdata, Bus_rdata;
    logic        Bus_wen, bus_valid, bus_ready;
    int          n_cmp = 0;
    int          n_err = 0;

    bus_arbiter #(.TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m1_req(m1_req), .m0_wen(m0_wen), .m1_wen(m1_wen),
        .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_done(m0_done), .m1_done(m1_done),
        .m_rdata(m_rdata), .m_err(m_err),
        .Bus_addr(Bus_addr), .Bus_wen(Bus_wen), .Bus_wdata(Bus_wdata), .bus_valid(bus_valid),
        .Bus_rdata(Bus_rdata), .bus_ready(bus_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 0; m0_req = 1; m1_req = 0; m0_wen = 0; m1_wen = 0;
        m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
        Bus_rdata = 0; bus_ready = 0;
        tick(); tick();
        settle();
        chk("rst_gnt0", m0_gnt, 0);
        chk("rst_valid", bus_valid, 0);
        chk("rst_done", {m0_done, m1_done}, 0);
        chk("rst_rdata", m_rdata, 0);
        chk("rst_err", m_err, 0);
        chk("rst_bus", {Bus_wen, Bus_addr[0]}, 0);
        // both request after reset: m0 first, then m1
        rst_n = 1; m0_req = 1; m1_req = 1;
        m0_addr = 32'h0000_0A00; m1_addr = 32'h0000_0B00; m1_wen = 1; m1_wdata = 32'h5555_AAAA;
        settle();
        chk("rr1_gnt", {m0_gnt, m1_gnt}, 2'b10);
        tick();
        m0_req = 0; bus_ready = 1; Bus_rdata = 32'h1111_1111;
        settle();
        chk("rr1_busy_gnt", {m0_gnt, m1_gnt}, 0);
        chk("rr1_valid", bus_valid, 1);
        chk("rr1_addr", Bus_addr, 32'h0000_0A00);
        tick();
        bus_ready = 0;
        settle();
        chk("rr1_done", {m0_done, m1_done}, 2'b10);
        chk("rr1_rdata", m_rdata, 32'h1111_1111);
        chk("rr1_resp_gnt", m1_gnt, 0);
        tick();
        m0_req = 1;
        settle();
        chk("rr2_gnt", {m0_gnt, m1_gnt}, 2'b01);
        tick();
        m1_req = 0; bus_ready = 1; Bus_rdata = 32'hFFFF_0000;
        settle();
        chk("rr2_wen", Bus_wen, 1);
        chk("rr2_addr", Bus_addr, 32'h0000_0B00);
        chk("rr2_wdata", Bus_wdata, 32'h5555_AAAA);
        tick();
        bus_ready = 0;
        settle();
        chk("rr2_done", {m0_done, m1_done}, 2'b01);
        chk("rr2_rdata", m_rdata, 0);
        chk("rr2_resp_gnt", m0_gnt, 0);
        tick();
        settle();
        chk("rr3_gnt", {m0_gnt, m1_gnt}, 2'b10);
        tick();
        m0_req = 0; bus_ready = 1; Bus_rdata = 32'h2222_2222;
        tick();
        bus_ready = 0;
        settle();
        chk("rr3_done", {m0_done, m1_done}, 2'b10);
        tick();
        m0_req = 1; m1_req = 1; m1_wen = 0; m1_addr = 32'h0000_0C00;
        settle();
        chk("rr4_gnt", {m0_gnt, m1_gnt}, 2'b01);
        tick();
        m1_req = 0; bus_ready = 1; Bus_rdata = 32'h4444_4444;
        tick();
        bus_ready = 0;
        settle();
        chk("rr4_done", {m0_done, m1_done}, 2'b01);
        chk("rr4_rdata", m_rdata, 32'h4444_4444);
        tick();
        settle();
        chk("rr5_gnt", {m0_gnt, m1_gnt}, 2'b10);
        tick();
        m0_req = 0; bus_ready = 1; Bus_rdata = 32'h3333_3333;
        tick();
        bus_ready = 0;
        settle();
        chk("rr5_done", {m0_done, m1_done}, 2'b10);
        tick();
        // single read from m0 while pointer favours m1
        m0_req = 1; m0_wen = 0; m0_addr = 32'h0000_1000;
        settle();
        chk("rd_gnt", {m0_gnt, m1_gnt}, 2'b10);
        chk("rd_idle_valid", bus_valid, 0);
        tick();
        m0_req = 0; m0_addr = 32'hBAD0_0000; bus_ready = 1; Bus_rdata = 32'hDEAD_BEEF;
        settle();
        chk("rd_valid", bus_valid, 1);
        chk("rd_addr", Bus_addr, 32'h0000_1000);
        chk("rd_wen", Bus_wen, 0);
        tick();
        bus_ready = 0;
        settle();
        chk("rd_done", {m0_done, m1_done}, 2'b10);
        chk("rd_rdata", m_rdata, 32'hDEAD_BEEF);
        chk("rd_err", m_err, 0);
        chk("rd_resp_valid", bus_valid, 0);
        tick();
        settle();
        chk("rd_done_drop", {m0_done, m1_done}, 0);
        chk("rd_hold", m_rdata, 32'hDEAD_BEEF);
        // m1 write with 3 wait cycles; bus_ready while idle must be ignored
        bus_ready = 1; Bus_rdata = 32'h0BAD_0BAD;
        settle();
        chk("idle_ready_ignored", {m0_done, m1_done, bus_valid}, 0);
        bus_ready = 0;
        m1_req = 1; m1_wen = 1; m1_addr = 32'h8000_0004; m1_wdata = 32'h1234_5678;
        settle();
        chk("wr_gnt", {m0_gnt, m1_gnt}, 2'b01);
        tick();
        m1_req = 0; m1_wen = 0; m1_addr = 32'h0; m1_wdata = 32'h0;
        for (int i = 0; i < 4; i++) begin
            bus_ready = (i == 3); Bus_rdata = 32'hFFFF_FFFF;
            settle();
            chk($sformatf("wr_bus%0d", i), {bus_valid, Bus_wen}, 2'b11);
            chk($sformatf("wr_addr%0d", i), Bus_addr, 32'h8000_0004);
            chk($sformatf("wr_wdata%0d", i), Bus_wdata, 32'h1234_5678);
            chk($sformatf("wr_nodone%0d", i), {m0_done, m1_done}, 0);
            tick();
        end
        bus_ready = 0;
        settle();
        chk("wr_done", {m0_done, m1_done}, 2'b01);
        chk("wr_rdata", m_rdata, 0);
        chk("wr_err", m_err, 0);
        chk("wr_resp_bus", {Bus_wen, Bus_addr, Bus_wdata}, 0);
        tick();
        // timeout: 16 BUSY cycles with bus_ready low
        m0_req = 1; m0_addr = 32'h0000_0040;
        settle();
        chk("to_gnt", m0_gnt, 1);
        tick();
        m0_req = 0;
        for (int i = 1; i <= 16; i++) begin
            settle();
            chk($sformatf("to_busy%0d", i), {bus_valid, m0_done}, 2'b10);
            tick();
        end
        settle();
        chk("to_done", {m0_done, m1_done}, 2'b10);
        chk("to_err", m_err, 1);
        chk("to_rdata", m_rdata, 0);
        chk("to_valid", bus_valid, 0);
        tick();
        // ready arriving on the 16th cycle wins over the timeout
        m0_req = 1;
        settle();
        chk("to2_gnt", m0_gnt, 1);
        tick();
        m0_req = 0;
        for (int i = 1; i <= 16; i++) begin
            bus_ready = (i == 16); Bus_rdata = 32'hCAFE_F00D;
            settle();
            chk($sformatf("to2_busy%0d", i), bus_valid, 1);
            tick();
        end
        bus_ready = 0;
        settle();
        chk("to2_done", m0_done, 1);
        chk("to2_err", m_err, 0);
        chk("to2_rdata", m_rdata, 32'hCAFE_F00D);
        tick();
        // reset mid-BUSY: no done, operands cleared, pointer back to m0
        m0_req = 1; m0_addr = 32'h0000_0050;
        settle();
        chk("rb_gnt", m0_gnt, 1);
        tick();
        m0_req = 0; rst_n = 0;
        settle();
        chk("rb_between_edges", bus_valid, 1);
        tick();
        rst_n = 1; m0_req = 1; m1_req = 1; m0_addr = 32'h0000_0060;
        settle();
        chk("rb_valid", bus_valid, 0);
        chk("rb_nodone", {m0_done, m1_done}, 0);
        chk("rb_rdata", m_rdata, 0);
        chk("rb_gnt2", {m0_gnt, m1_gnt}, 2'b10);
        tick();
        m0_req = 0; m1_req = 0; bus_ready = 1; Bus_rdata = 32'h7777_7777;
        settle();
        chk("rb_addr", Bus_addr, 32'h0000_0060);
        chk("rb_nodone2", {m0_done, m1_done}, 0);
        tick();
        bus_ready = 0;
        settle();
        chk("rb_done", {m0_done, m1_done}, 2'b10);
        chk("rb_rdata2", m_rdata, 32'h7777_7777);
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, max BUSY cycles waiting for bus_ready before abort (range 2..255).
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have ports m0_req / m1_req  input  1 each  request from master 0 (CPU data port) / master 1 (loader/debug).
REQ-005 SHALL have ports m0_wen, m1_wen  input  1 each  write (1) or read (0).
REQ-006 SHALL have ports m0_addr, m1_addr, m0_wdata, m1_wdata  input  32 each  address, write data.
REQ-007 SHALL have ports m0_gnt, m1_gnt  output  1 each  one-cycle pulse: request accepted, operands latched.
REQ-008 SHALL have ports m0_done, m1_done  output  1 each  one-cycle completion pulse.
REQ-009 SHALL have ports m_rdata  output  32  read data; m_err  output  1  timeout flag; both valid while any mX_done=1.
REQ-010 SHALL have ports Bus_addr  output  32, Bus_wen  output  1, Bus_wdata  output  32, bus_valid  output  1  slave request side.
REQ-011 SHALL have ports Bus_rdata  input  32, bus_ready  input  1  slave response side.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, RESP; one transaction in flight at most.
REQ-013 IDLE: no request -> stay IDLE, all pulses 0, bus_valid=0.
REQ-014 IDLE, exactly one mX_req=1 -> latch that master's wen/addr/wdata, pulse mX_gnt next... in the same cycle as the IDLE->BUSY transition edge (gnt combinational in IDLE, 1 cycle wide), record owner=X.
REQ-015 IDLE, both requests -> grant the master that did NOT own the last completed transaction (round-robin); after reset the priority pointer selects m0.
REQ-016 A master SHALL hold req and operands stable until its gnt; after gnt it may drop or change them without effect on the transaction.
REQ-017 BUSY: bus_valid=1; Bus_addr/Bus_wen/Bus_wdata driven from latched registers, stable for the whole BUSY period.
REQ-018 Bus_wen SHALL be 1 only in BUSY with latched wen=1; Bus_addr, Bus_wdata SHALL be 0 outside BUSY.
REQ-019 BUSY with bus_ready=1 -> capture Bus_rdata (0 for writes) into rdata register, err=0, go RESP; minimum latency gnt-to-done = 2 cycles.
REQ-020 BUSY: 8-bit wait counter cleared on entry, +1 per cycle with bus_ready=0; counter reaching TIMEOUT-1 with bus_ready=0 -> rdata=0, err=1, go RESP.
REQ-021 bus_ready=1 in the same cycle as the timeout condition SHALL count as success (err=0).
REQ-022 RESP: pulse m{owner}_done for exactly one cycle, drive m_rdata/m_err, toggle priority pointer away from owner, go IDLE; no grant issued in RESP.
REQ-023 bus_ready outside BUSY SHALL be ignored.
REQ-024 m_rdata and m_err SHALL hold their last values until the next RESP.
REQ-025 Back-to-back: a request pending in RESP SHALL be granted in the immediately following IDLE cycle (3-cycle minimum per transaction for a single master).

Reset
REQ-026 rst_n=0 at a clock edge SHALL force IDLE, pointer=m0, counter=0, latched operands=0, m_rdata=0, m_err=0; all gnt/done/bus_valid/Bus_wen=0 from that edge.
REQ-027 Reset during BUSY or RESP SHALL abort the transaction without any done pulse; rst_n asserted between edges SHALL have no effect until the next edge.

Verification
REQ-028 Single read: m0_req, addr=0x0000_1000, bus_ready 1 cycle later with Bus_rdata=0xDEAD_BEEF -> m0_gnt cycle 0, bus_valid cycles 1, m0_done cycle 2 with m_rdata=0xDEAD_BEEF, m_err=0.
REQ-029 Simultaneous requests after reset, both held -> m0 granted first, m1 granted in IDLE after m0_done; repeat -> m1 then m0 order alternates correctly.
REQ-030 Write m1 addr=0x8000_0004 wdata=0x1234_5678, bus_ready after 3 wait cycles -> Bus_wen=1 and stable operands for 4 BUSY cycles, m1_done with m_rdata=0.
REQ-031 Timeout: TIMEOUT=16, bus_ready held 0 -> exactly 16 BUSY cycles, then m0_done with m_err=1, m_rdata=0; bus_ready=1 on cycle 16 instead -> m_err=0.
REQ-032 Reset mid-BUSY: rst_n=0 for one edge during BUSY -> no done pulse, bus_valid=0 next cycle, next simultaneous request grants m0.
